zeroheti_obi_arbiter: RTL and testbench

ZEROHETI_OBI_ARBITER -- requirements
Module: zeroheti_obi_arbiter

---
 rtl/zeroheti_obi_arbiter.sv | 143 ++++++++++++++
 tb/tb_zeroheti_obi_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/zeroheti_obi_arbiter.sv
// Round-robin arbiter funnelling several OBI requesters onto one shared
// subordinate port, with at most one transaction outstanding at any time.
module zeroheti_obi_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned IdxW     = $clog2(NumReq),
  localparam int unsigned BeW      = DataWidth / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq-1:0][BeW-1:0]          req_be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
  output logic [NumReq-1:0]                   req_gnt_o,
  output logic [NumReq-1:0]                   req_rvalid_o,
  output logic [DataWidth-1:0]                req_rdata_o,
  output logic                                req_err_o,
  output logic                                sbr_req_o,
  output logic [AddrWidth-1:0]                sbr_addr_o,
  output logic                                sbr_we_o,
  output logic [BeW-1:0]                      sbr_be_o,
  output logic [DataWidth-1:0]                sbr_wdata_o,
  input  logic                                sbr_gnt_i,
  input  logic                                sbr_rvalid_i,
  input  logic [DataWidth-1:0]                sbr_rdata_i,
  input  logic                                sbr_err_i,
  output logic                                busy_o,
  output logic [IdxW-1:0]                     owner_o
);

  // IDLE: free to arbitrate; HOLD: address phase locked to owner, not yet
  // granted; BUSY: granted, waiting for the single outstanding response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;

  logic            sel_valid;
  logic [IdxW-1:0] sel_idx;
  logic            fwd;
  logic [IdxW-1:0] fwd_idx;

  // Round-robin pick: first requester after ptr, wrapping modulo NumReq.
  // Scanning from the far end backwards lets the nearest candidate win.
  always_comb begin
    int cand;
    cand      = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = int'(NumReq); k >= 1; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= int'(NumReq)) cand = cand - int'(NumReq);
      if (req_req_i[IdxW'(cand)]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  // Next-state, ownership and pointer update; decides which requester (if
  // any) is forwarded to the subordinate this cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    fwd          = 1'b0;
    fwd_idx      = owner_q;
    req_rvalid_o = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          fwd     = 1'b1;
          fwd_idx = sel_idx;
          owner_d = sel_idx;
          state_d = sbr_gnt_i ? BUSY : HOLD;
        end
      end
      HOLD: begin
        // Keep the selection stable; other requesters cannot preempt it.
        if (req_req_i[owner_q]) begin
          fwd     = 1'b1;
          fwd_idx = owner_q;
          if (sbr_gnt_i) state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (sbr_rvalid_i) begin
          req_rvalid_o[owner_q] = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The pointer only advances on a completed address handshake.
    if (fwd && sbr_gnt_i) ptr_d = fwd_idx;
  end

  // Address-phase mux and grant routing towards the forwarded requester.
  always_comb begin
    req_gnt_o   = '0;
    sbr_req_o   = fwd;
    sbr_addr_o  = '0;
    sbr_we_o    = 1'b0;
    sbr_be_o    = '0;
    sbr_wdata_o = '0;
    if (fwd) begin
      sbr_addr_o         = req_addr_i[fwd_idx];
      sbr_we_o           = req_we_i[fwd_idx];
      sbr_be_o           = req_be_i[fwd_idx];
      sbr_wdata_o        = req_wdata_i[fwd_idx];
      req_gnt_o[fwd_idx] = sbr_gnt_i;
    end
  end

  // State registers; reset makes index 0 the first winner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= IdxW'(NumReq - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign req_rdata_o = sbr_rdata_i;
  assign req_err_o   = sbr_err_i;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
// Scoreboard bench for zeroheti_obi_arbiter: a transaction-level model
// predicts each cycle's response; a monitor compares on the falling edge.
module tb_zeroheti_obi_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int IW = $clog2(N);

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic [N-1:0]           req_req;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0]           req_we;
  logic [N-1:0][BW-1:0]   req_be;
  logic [N-1:0][DW-1:0]   req_wdata;
  logic [N-1:0]           req_gnt;
  logic [N-1:0]           req_rvalid;
  logic [DW-1:0]          req_rdata;
  logic                   req_err;
  logic                   sbr_req;
  logic [AW-1:0]          sbr_addr;
  logic                   sbr_we;
  logic [BW-1:0]          sbr_be;
  logic [DW-1:0]          sbr_wdata;
  logic                   sbr_gnt;
  logic                   sbr_rvalid;
  logic [DW-1:0]          sbr_rdata;
  logic                   sbr_err;
  logic                   busy;
  logic [IW-1:0]          owner;

  zeroheti_obi_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_req_i(req_req), .req_addr_i(req_addr), .req_we_i(req_we),
    .req_be_i(req_be), .req_wdata_i(req_wdata),
    .req_gnt_o(req_gnt), .req_rvalid_o(req_rvalid),
    .req_rdata_o(req_rdata), .req_err_o(req_err),
    .sbr_req_o(sbr_req), .sbr_addr_o(sbr_addr), .sbr_we_o(sbr_we),
    .sbr_be_o(sbr_be), .sbr_wdata_o(sbr_wdata),
    .sbr_gnt_i(sbr_gnt), .sbr_rvalid_i(sbr_rvalid),
    .sbr_rdata_i(sbr_rdata), .sbr_err_i(sbr_err),
    .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic          sreq;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic          busy;
    bit            chk_owner;
    int            owner;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t expq[$];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who holds a locked request, who is in flight, and who
  // was served last (round-robin restarts after the last served index).
  int lock_idx    = -1;
  bit inflight    = 1'b0;
  int inflight_id = 0;
  int last_served = N - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic cycle(input logic [N-1:0] rq, input logic g, input logic rv, input logic rst_a);
    exp_t e;
    int   pres;
    @(posedge clk);
    #1;
    rst_ni  = ~rst_a;
    req_req = rst_a ? '0 : rq;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = $urandom;
      req_we[i]    = 1'($urandom_range(0, 1));
      req_be[i]    = BW'($urandom);
      req_wdata[i] = $urandom;
    end
    sbr_gnt    = g;
    sbr_rvalid = rv;
    sbr_rdata  = $urandom;
    sbr_err    = 1'($urandom_range(0, 1));

    e.gnt = '0; e.rvalid = '0; e.sreq = 1'b0; e.addr = '0; e.we = 1'b0;
    e.be = '0; e.wdata = '0; e.rdata = sbr_rdata; e.err = sbr_err;
    if (rst_a) begin
      e.busy = 1'b0; e.chk_owner = 1'b1; e.owner = 0;
      expq.push_back(e);
      lock_idx = -1; inflight = 1'b0; last_served = N - 1;
      return;
    end
    e.busy      = inflight || (lock_idx >= 0);
    e.chk_owner = e.busy;
    e.owner     = inflight ? inflight_id : lock_idx;
    pres = -1;
    if (inflight) begin
      if (rv) begin
        e.rvalid[inflight_id] = 1'b1;
        inflight = 1'b0;
      end
    end else if (lock_idx >= 0) begin
      if (rq[lock_idx]) pres = lock_idx;
      else lock_idx = -1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_served + k) % N;
        if (rq[c] && pres < 0) pres = c;
      end
    end
    if (pres >= 0) begin
      e.sreq  = 1'b1;
      e.addr  = req_addr[pres];
      e.we    = req_we[pres];
      e.be    = req_be[pres];
      e.wdata = req_wdata[pres];
      if (g) begin
        e.gnt[pres] = 1'b1;
        inflight    = 1'b1;
        inflight_id = pres;
        last_served = pres;
        lock_idx    = -1;
      end else begin
        lock_idx = pres;
      end
    end
    expq.push_back(e);
  endtask

  // Monitor: compare the DUT's outputs with the oldest prediction.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("gnt",    64'(req_gnt),    64'(e.gnt));
      chk("rvalid", 64'(req_rvalid), 64'(e.rvalid));
      chk("sbr_req", 64'(sbr_req),   64'(e.sreq));
      chk("sbr_addr", 64'(sbr_addr), 64'(e.addr));
      chk("sbr_we", 64'(sbr_we),     64'(e.we));
      chk("sbr_be", 64'(sbr_be),     64'(e.be));
      chk("sbr_wdata", 64'(sbr_wdata), 64'(e.wdata));
      chk("rdata",  64'(req_rdata),  64'(e.rdata));
      chk("err",    64'(req_err),    64'(e.err));
      chk("busy",   64'(busy),       64'(e.busy));
      if (e.chk_owner) chk("owner", 64'(owner), 64'(e.owner));
    end
  end

  initial begin
    rst_ni = 1'b0; req_req = '0; req_addr = '0; req_we = '0; req_be = '0;
    req_wdata = '0; sbr_gnt = 1'b0; sbr_rvalid = 1'b0; sbr_rdata = '0; sbr_err = 1'b0;
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0, 1'b1);

    // All requesting, immediate grant, response one cycle later: 0,1,2,0.
    for (int i = 0; i < 4; i++) begin
      cycle(3'b111, 1'b1, 1'b0, 1'b0);
      cycle(3'b111, 1'b1, 1'b1, 1'b0);
    end
    // Stray responses while idle.
    cycle(3'b000, 1'b0, 1'b1, 1'b0);
    cycle(3'b000, 1'b1, 1'b1, 1'b0);

    // Locked request: req2 arrives while req0 waits for its grant.
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle(3'b001, 1'b0, 1'b0, 1'b0);
    cycle(3'b101, 1'b0, 1'b0, 1'b0);
    cycle(3'b101, 1'b0, 1'b1, 1'b0);
    cycle(3'b101, 1'b1, 1'b0, 1'b0);
    cycle(3'b100, 1'b1, 1'b1, 1'b0);
    cycle(3'b100, 1'b1, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b1, 1'b0);

    // Request raised during BUSY is not granted in the response cycle.
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle(3'b010, 1'b1, 1'b0, 1'b0);
    cycle(3'b011, 1'b1, 1'b1, 1'b0);
    cycle(3'b001, 1'b1, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b1, 1'b0);

    // Reset while BUSY on req2, then a late stray response.
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle(3'b100, 1'b1, 1'b0, 1'b0);
    cycle(3'b111, 1'b1, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, 1'b1, 1'b0);
    cycle(3'b111, 1'b1, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b1, 1'b0);

    // Owner withdraws during HOLD; priority order is unchanged.
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle(3'b111, 1'b1, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b1, 1'b0);
    cycle(3'b010, 1'b0, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b0, 1'b0);
    cycle(3'b111, 1'b1, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(N'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
